// File: rtl/id_exe_stage_reg_pkg.sv
// Shared constants for the ID->EXE pipeline register.
//   WORD_WIDTH     - datapath word width
//   REG_FILE_DEPTH - width of a register index
//   EXE_CMD_WIDTH  - width of the ALU command field
package id_exe_stage_reg_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_FILE_DEPTH = 4;
    localparam int unsigned EXE_CMD_WIDTH  = 4;

    // True when an active write-back targets the source register of a live held instruction.
    function automatic logic wb_hits_src(
        input logic                      wb_en,
        input logic [REG_FILE_DEPTH-1:0] wb_dest,
        input logic [REG_FILE_DEPTH-1:0] src,
        input logic                      valid
    );
        return wb_en && valid && (wb_dest == src);
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating event counter.
//   clk, rst - clock and asynchronous active-high reset
//   inc      - count one event this cycle
//   count    - current value; sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count;
        if (inc && (count != '1)) begin
            count_d = count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze, flush, valid tag and stall/flush counters.
//   clk, rst           - clock, asynchronous active-high reset
//   freeze, flush      - hold contents / insert bubble (flush wins)
//   valid_in, *_in     - decoded instruction and operands from ID
//   WB_EN/WB_Dest/WB_Res - write-back port, used to refresh held operands while frozen
//   *_out, valid_out   - registered copy of every *_in field
//   stall_cnt, flush_cnt - saturating event counters
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int unsigned          CNT_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [WORD_WIDTH-1:0]     PC_in,
    input  logic [WORD_WIDTH-1:0]     Val_Rn_in,
    input  logic [WORD_WIDTH-1:0]     Val_Rm_in,
    input  logic [REG_FILE_DEPTH-1:0] src1_in,
    input  logic [REG_FILE_DEPTH-1:0] src2_in,
    input  logic [REG_FILE_DEPTH-1:0] Dest_in,
    input  logic [EXE_CMD_WIDTH-1:0]  EXE_CMD_in,
    input  logic                      WB_EN_in,
    input  logic                      MEM_R_EN_in,
    input  logic                      MEM_W_EN_in,
    input  logic                      B_in,
    input  logic                      S_in,
    input  logic                      Imm_in,
    input  logic [11:0]               Shift_Operand_in,
    input  logic [23:0]               Signed_imm_24_in,
    input  logic                      C_in,
    input  logic                      WB_EN,
    input  logic [REG_FILE_DEPTH-1:0] WB_Dest,
    input  logic [WORD_WIDTH-1:0]     WB_Res,
    output logic                      valid_out,
    output logic [WORD_WIDTH-1:0]     PC_out,
    output logic [WORD_WIDTH-1:0]     Val_Rn_out,
    output logic [WORD_WIDTH-1:0]     Val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0] src1_out,
    output logic [REG_FILE_DEPTH-1:0] src2_out,
    output logic [REG_FILE_DEPTH-1:0] Dest_out,
    output logic [EXE_CMD_WIDTH-1:0]  EXE_CMD_out,
    output logic                      WB_EN_out,
    output logic                      MEM_R_EN_out,
    output logic                      MEM_W_EN_out,
    output logic                      B_out,
    output logic                      S_out,
    output logic                      Imm_out,
    output logic [11:0]               Shift_Operand_out,
    output logic [23:0]               Signed_imm_24_out,
    output logic                      C_out,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    logic stall_inc;
    logic rn_hit;
    logic rm_hit;

    assign stall_inc = freeze && !flush;
    assign rn_hit    = wb_hits_src(WB_EN, WB_Dest, src1_out, valid_out);
    assign rm_hit    = wb_hits_src(WB_EN, WB_Dest, src2_out, valid_out);

    // Control: a flush kills every side-effecting bit; Imm, C and EXE_CMD simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            B_out        <= 1'b0;
            S_out        <= 1'b0;
            Imm_out      <= 1'b0;
            C_out        <= 1'b0;
            EXE_CMD_out  <= '0;
        end else if (flush) begin
            valid_out    <= 1'b0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            B_out        <= 1'b0;
            S_out        <= 1'b0;
        end else if (!freeze) begin
            valid_out    <= valid_in;
            WB_EN_out    <= WB_EN_in;
            MEM_R_EN_out <= MEM_R_EN_in;
            MEM_W_EN_out <= MEM_W_EN_in;
            B_out        <= B_in;
            S_out        <= S_in;
            Imm_out      <= Imm_in;
            C_out        <= C_in;
            EXE_CMD_out  <= EXE_CMD_in;
        end
    end

    // Data: held on flush; while frozen the operands track write-backs to their sources.
    // No bypass on load - the register file writes on negedge, so reg1/reg2 are already fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out            <= RESET_PC;
            Val_Rn_out        <= '0;
            Val_Rm_out        <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            Dest_out          <= '0;
            Shift_Operand_out <= '0;
            Signed_imm_24_out <= '0;
        end else if (flush) begin
            PC_out <= PC_out;
        end else if (freeze) begin
            if (rn_hit) begin
                Val_Rn_out <= WB_Res;
            end
            if (rm_hit) begin
                Val_Rm_out <= WB_Res;
            end
        end else begin
            PC_out            <= PC_in;
            Val_Rn_out        <= Val_Rn_in;
            Val_Rm_out        <= Val_Rm_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            Dest_out          <= Dest_in;
            Shift_Operand_out <= Shift_Operand_in;
            Signed_imm_24_out <= Signed_imm_24_in;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;
    import id_exe_stage_reg_pkg::*;

    localparam int unsigned          CW     = 4;
    localparam logic [WORD_WIDTH-1:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0, flush = 1'b0, valid_in = 1'b0;
    logic [31:0] PC_in = '0, Val_Rn_in = '0, Val_Rm_in = '0, WB_Res = '0;
    logic [3:0]  src1_in = '0, src2_in = '0, Dest_in = '0, EXE_CMD_in = '0, WB_Dest = '0;
    logic        WB_EN_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0;
    logic        B_in = 1'b0, S_in = 1'b0, Imm_in = 1'b0, C_in = 1'b0, WB_EN = 1'b0;
    logic [11:0] Shift_Operand_in = '0;
    logic [23:0] Signed_imm_24_in = '0;

    logic        valid_out;
    logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
    logic [3:0]  src1_out, src2_out, Dest_out, EXE_CMD_out;
    logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, Imm_out, C_out;
    logic [11:0] Shift_Operand_out;
    logic [23:0] Signed_imm_24_out;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_exe_stage_reg #(
        .CNT_WIDTH (CW),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk (clk), .rst (rst), .freeze (freeze), .flush (flush), .valid_in (valid_in),
        .PC_in (PC_in), .Val_Rn_in (Val_Rn_in), .Val_Rm_in (Val_Rm_in),
        .src1_in (src1_in), .src2_in (src2_in), .Dest_in (Dest_in), .EXE_CMD_in (EXE_CMD_in),
        .WB_EN_in (WB_EN_in), .MEM_R_EN_in (MEM_R_EN_in), .MEM_W_EN_in (MEM_W_EN_in),
        .B_in (B_in), .S_in (S_in), .Imm_in (Imm_in),
        .Shift_Operand_in (Shift_Operand_in), .Signed_imm_24_in (Signed_imm_24_in),
        .C_in (C_in), .WB_EN (WB_EN), .WB_Dest (WB_Dest), .WB_Res (WB_Res),
        .valid_out (valid_out), .PC_out (PC_out), .Val_Rn_out (Val_Rn_out),
        .Val_Rm_out (Val_Rm_out), .src1_out (src1_out), .src2_out (src2_out),
        .Dest_out (Dest_out), .EXE_CMD_out (EXE_CMD_out), .WB_EN_out (WB_EN_out),
        .MEM_R_EN_out (MEM_R_EN_out), .MEM_W_EN_out (MEM_W_EN_out), .B_out (B_out),
        .S_out (S_out), .Imm_out (Imm_out), .Shift_Operand_out (Shift_Operand_out),
        .Signed_imm_24_out (Signed_imm_24_out), .C_out (C_out),
        .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    typedef struct {
        logic        valid, wb_en, mem_r, mem_w, b, s, imm, c;
        logic [3:0]  cmd, src1, src2, dest;
        logic [31:0] pc, rn, rm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [CW-1:0] stall, fl;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    function automatic exp_t reset_model();
        exp_t r;
        r = '{valid: 0, wb_en: 0, mem_r: 0, mem_w: 0, b: 0, s: 0, imm: 0, c: 0,
              cmd: 0, src1: 0, src2: 0, dest: 0, pc: RST_PC, rn: 0, rm: 0,
              shift: 0, simm: 0, stall: 0, fl: 0};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(valid_out), 32'(e.valid));
        chk({tag, ".ctrl"},
            32'({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, Imm_out, C_out}),
            32'({e.wb_en, e.mem_r, e.mem_w, e.b, e.s, e.imm, e.c}));
        chk({tag, ".cmd"}, 32'(EXE_CMD_out), 32'(e.cmd));
        chk({tag, ".pc"}, PC_out, e.pc);
        chk({tag, ".rn"}, Val_Rn_out, e.rn);
        chk({tag, ".rm"}, Val_Rm_out, e.rm);
        chk({tag, ".regs"}, 32'({src1_out, src2_out, Dest_out}), 32'({e.src1, e.src2, e.dest}));
        chk({tag, ".shift"}, 32'(Shift_Operand_out), 32'(e.shift));
        chk({tag, ".simm"}, 32'(Signed_imm_24_out), 32'(e.simm));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fl));
    endtask

    // Reference model: computes the state after the next edge from the current inputs.
    function automatic exp_t next_model(input exp_t cur);
        exp_t n = cur;
        if (flush) begin
            n.valid = 0; n.wb_en = 0; n.mem_r = 0; n.mem_w = 0; n.b = 0; n.s = 0;
            if (cur.fl != {CW{1'b1}}) n.fl = cur.fl + 1'b1;
        end else if (freeze) begin
            if (cur.stall != {CW{1'b1}}) n.stall = cur.stall + 1'b1;
            if (cur.valid && WB_EN && WB_Dest == cur.src1) n.rn = WB_Res;
            if (cur.valid && WB_EN && WB_Dest == cur.src2) n.rm = WB_Res;
        end else begin
            n.valid = valid_in; n.wb_en = WB_EN_in; n.mem_r = MEM_R_EN_in;
            n.mem_w = MEM_W_EN_in; n.b = B_in; n.s = S_in; n.imm = Imm_in; n.c = C_in;
            n.cmd = EXE_CMD_in; n.src1 = src1_in; n.src2 = src2_in; n.dest = Dest_in;
            n.pc = PC_in; n.rn = Val_Rn_in; n.rm = Val_Rm_in;
            n.shift = Shift_Operand_in; n.simm = Signed_imm_24_in;
        end
        return n;
    endfunction

    // Push expectation at drive time, pop and compare one edge later.
    task automatic step(input string tag);
        exp_t e;
        m = next_model(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_all(tag, e);
        end
    endtask

    task automatic rand_inputs();
        valid_in = 1'($urandom); PC_in = $urandom; Val_Rn_in = $urandom; Val_Rm_in = $urandom;
        src1_in = 4'($urandom); src2_in = 4'($urandom); Dest_in = 4'($urandom);
        EXE_CMD_in = 4'($urandom); WB_EN_in = 1'($urandom); MEM_R_EN_in = 1'($urandom);
        MEM_W_EN_in = 1'($urandom); B_in = 1'($urandom); S_in = 1'($urandom);
        Imm_in = 1'($urandom); C_in = 1'($urandom);
        Shift_Operand_in = 12'($urandom); Signed_imm_24_in = 24'($urandom);
    endtask

    initial begin
        // Reset state while rst is held
        m = reset_model();
        rand_inputs();
        #12;
        check_all("reset", m);
        @(negedge clk);
        rst = 1'b0;

        // Plain load
        rand_inputs();
        valid_in = 1; PC_in = 32'h10; Val_Rn_in = 32'hDEAD_BEEF; Dest_in = 4'd5;
        WB_EN_in = 1; MEM_W_EN_in = 1; B_in = 1; src1_in = 4'd3; src2_in = 4'd3;
        step("load");

        // Freeze 3 cycles with changing inputs, no write-back
        freeze = 1; WB_EN = 0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("freeze_hold");
        end
        chk("stall_cnt_after_3", 32'(stall_cnt), 32'd3);

        // Refresh both operands from the same write-back
        WB_EN = 1; WB_Dest = 4'd3; WB_Res = 32'h55;
        step("refresh_both");
        chk("refresh_rn_0x55", Val_Rn_out, 32'h55);

        // Write-back to an unrelated register
        WB_Dest = 4'd4; WB_Res = 32'h77;
        step("refresh_miss");

        // Independent refresh: only src2 matches
        freeze = 0; WB_EN = 0;
        rand_inputs();
        valid_in = 1; src1_in = 4'd2; src2_in = 4'd7; WB_EN_in = 1;
        step("load2");
        freeze = 1; WB_EN = 1; WB_Dest = 4'd7; WB_Res = 32'hCAFE_0007;
        step("refresh_rm_only");

        // Flush while frozen: bubble, flush_cnt+1, stall_cnt unchanged
        flush = 1; rand_inputs();
        step("flush_frozen");
        flush = 0;

        // Frozen bubble: no refresh even though WB targets src2
        WB_Dest = 4'd7; WB_Res = 32'h1234;
        step("freeze_invalid");

        // Mixed random traffic
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            flush = ($urandom_range(0, 4) == 0);
            freeze = ($urandom_range(0, 2) == 0);
            WB_EN = 1'($urandom); WB_Dest = 4'($urandom_range(0, 3)); WB_Res = $urandom;
            step("random");
        end

        // Reset mid-cycle during freeze: immediate, then a normal load
        freeze = 1; flush = 0;
        @(negedge clk);
        rst = 1;
        #1;
        m = reset_model();
        sb.delete();
        check_all("reset_mid", m);
        @(posedge clk);
        #1;
        check_all("reset_held", m);
        freeze = 0; rand_inputs(); valid_in = 1;
        #2;
        rst = 0;
        step("load_after_reset");

        // Stall counter saturation: 2^CW + 2 freeze cycles
        freeze = 1; WB_EN = 0;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            rand_inputs();
            step("stall_sat");
        end
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'hF);

        // Flush counter saturation
        flush = 1;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            rand_inputs();
            step("flush_sat");
        end
        chk("flush_cnt_saturated", 32'(flush_cnt), 32'hF);
        flush = 0; freeze = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
